// File: rtl/hzrd_stall_ctrl.sv
// Load-use / RAW hazard detector with a multi-cycle stall FSM for slow memories, plus perf counters.
// Latency: hazard/bubble are combinational from ID/EXE/MEM fields; the stall extends MEM_LAT cycles past detection.
// Backpressure: hazard freezes PC and IF/ID; bubble squashes ID/EXE; flush overrides both in any state.
module hzrd_stall_ctrl #(
    parameter int RW      = 4,
    parameter int MEM_LAT = 0,
    parameter int CW      = 3,
    parameter int PW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] src1,
    input  logic [RW-1:0] src2,
    input  logic          src1_vld,
    input  logic          src2_vld,
    input  logic [RW-1:0] exe_dest,
    input  logic          exe_wb_en,
    input  logic          exe_mem_r_en,
    input  logic [RW-1:0] mem_dest,
    input  logic          mem_wb_en,
    input  logic          forward_en,
    input  logic          flush,
    output logic          hazard,
    output logic          bubble,
    output logic [PW-1:0] stall_cycles,
    output logic [PW-1:0] hazard_events
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit            HAS_LAT  = (MEM_LAT > 0);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic m1x, m2x, m1m, m2m;
    logic raw;

    assign m1x = src1_vld & (src1 == exe_dest);
    assign m2x = src2_vld & (src2 == exe_dest);
    assign m1m = src1_vld & (src1 == mem_dest);
    assign m2m = src2_vld & (src2 == mem_dest);

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign raw = forward_en ? (exe_mem_r_en & exe_wb_en & (m1x | m2x))
                            : ((exe_wb_en & (m1x | m2x)) | (mem_wb_en & (m1m | m2m)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            cnt           <= '0;
            stall_cycles  <= '0;
            hazard_events <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (hazard && stall_cycles != '1)
                stall_cycles <= stall_cycles + PW'(1);
            if (hazard && state == RUN && hazard_events != '1)
                hazard_events <= hazard_events + PW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (HAS_LAT && forward_en && raw) begin
                        state_nxt = STALL;
                        cnt_nxt   = LAT_LOAD;
                    end
                end
                STALL: begin
                    // forward_en is deliberately ignored here: the countdown always completes.
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (rst && !flush) begin
            case (state)
                RUN:     hazard = raw;
                STALL:   hazard = 1'b1;
                default: hazard = 1'b0;
            endcase
        end
        bubble = hazard;
    end

endmodule

// File: tb/tb_hzrd_stall_ctrl.sv
// Bench for hzrd_stall_ctrl: three instances (MEM_LAT=0, MEM_LAT=2, MEM_LAT=2/PW=4) on shared inputs,
// checked each cycle against a remaining-stall-cycles model plus directed literal checks.
module tb_hzrd_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] src1 = '0, src2 = '0, exe_dest = '0, mem_dest = '0;
    logic       src1_vld = 1'b0, src2_vld = 1'b0;
    logic       exe_wb_en = 1'b0, exe_mem_r_en = 1'b0, mem_wb_en = 1'b0;
    logic       forward_en = 1'b0, flush = 1'b0;

    logic        hz [3];
    logic        bb [3];
    logic [15:0] sc0, ev0, sc2, ev2;
    logic [3:0]  sc4, ev4;
    logic [15:0] dsc [3];
    logic [15:0] dev [3];

    int vecs = 0;
    int misc = 0;

    always #5 clk = ~clk;

    hzrd_stall_ctrl #(.RW(4), .MEM_LAT(0), .CW(3), .PW(16)) u_l0 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1_vld(src1_vld), .src2_vld(src2_vld),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .forward_en(forward_en), .flush(flush),
        .hazard(hz[0]), .bubble(bb[0]), .stall_cycles(sc0), .hazard_events(ev0));

    hzrd_stall_ctrl #(.RW(4), .MEM_LAT(2), .CW(3), .PW(16)) u_l2 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1_vld(src1_vld), .src2_vld(src2_vld),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .forward_en(forward_en), .flush(flush),
        .hazard(hz[1]), .bubble(bb[1]), .stall_cycles(sc2), .hazard_events(ev2));

    hzrd_stall_ctrl #(.RW(4), .MEM_LAT(2), .CW(3), .PW(4)) u_p4 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1_vld(src1_vld), .src2_vld(src2_vld),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .forward_en(forward_en), .flush(flush),
        .hazard(hz[2]), .bubble(bb[2]), .stall_cycles(sc4), .hazard_events(ev4));

    assign dsc[0] = sc0;
    assign dsc[1] = sc2;
    assign dsc[2] = {12'b0, sc4};
    assign dev[0] = ev0;
    assign dev[1] = ev2;
    assign dev[2] = {12'b0, ev4};

    // Model: per instance, number of forced stall cycles still owed, plus plain saturating tallies.
    int lat_tab [3] = '{0, 2, 2};
    int max_tab [3] = '{65535, 65535, 15};
    int rem [3] = '{0, 0, 0};
    int msc [3] = '{0, 0, 0};
    int mev [3] = '{0, 0, 0};

    function automatic bit m_raw();
        bit exe_hit, mem_hit;
        exe_hit = exe_wb_en && ((src1_vld && src1 == exe_dest) || (src2_vld && src2 == exe_dest));
        mem_hit = mem_wb_en && ((src1_vld && src1 == mem_dest) || (src2_vld && src2 == mem_dest));
        if (forward_en) return exe_mem_r_en && exe_hit;
        return exe_hit || mem_hit;
    endfunction

    function automatic bit m_hz(int i);
        return rst && !flush && (rem[i] > 0 || m_raw());
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                rem[i] = 0; msc[i] = 0; mev[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit h;
                h = m_hz(i);
                if (h && msc[i] < max_tab[i]) msc[i] = msc[i] + 1;
                if (h && rem[i] == 0 && mev[i] < max_tab[i]) mev[i] = mev[i] + 1;
                if (flush) rem[i] = 0;
                else if (rem[i] > 0) rem[i] = rem[i] - 1;
                else if (h && forward_en && lat_tab[i] > 0) rem[i] = lat_tab[i];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model_hazard[%0d]", i), 32'(hz[i]), 32'(m_hz(i)));
            check($sformatf("model_bubble[%0d]", i), 32'(bb[i]), 32'(m_hz(i)));
            check($sformatf("model_stall_cycles[%0d]", i), 32'(dsc[i]), 32'(msc[i]));
            check($sformatf("model_hazard_events[%0d]", i), 32'(dev[i]), 32'(mev[i]));
        end
    end

    task automatic idle();
        src1 = '0; src2 = '0; exe_dest = '0; mem_dest = '0;
        src1_vld = 0; src2_vld = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        mem_wb_en = 0; forward_en = 0; flush = 0;
    endtask

    task automatic load_use();
        forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3;
        src2 = 4'd3; src2_vld = 1;
    endtask

    task automatic clear_exe();
        exe_mem_r_en = 0; exe_wb_en = 0; src2_vld = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        #1;
    endtask

    initial begin
        // Reset forces hazard low even with a live match on the inputs.
        idle();
        forward_en = 0; mem_wb_en = 1; mem_dest = 4'd5; src1 = 4'd5; src1_vld = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hazard_forced", 32'(hz[0]), 0);
        check("rst_bubble_forced", 32'(bb[1]), 0);
        check("rst_stall_cycles", 32'(sc0), 0);
        check("rst_hazard_events", 32'(ev2), 0);

        // 1: single-cycle memory load-use
        do_reset();
        load_use();
        #1 check("t1_hazard", 32'(hz[0]), 1);
        step();
        clear_exe();
        #1 check("t1_hazard_after", 32'(hz[0]), 0);
        check("t1_stall_cycles", 32'(sc0), 1);
        check("t1_hazard_events", 32'(ev0), 1);

        // 2: MEM_LAT=2 stalls for three cycles
        do_reset();
        load_use();
        #1 check("t2_hazard_c0", 32'(hz[1]), 1);
        step();
        clear_exe();
        #1 check("t2_hazard_c1", 32'(hz[1]), 1);
        step();
        check("t2_hazard_c2", 32'(hz[1]), 1);
        step();
        check("t2_hazard_c3", 32'(hz[1]), 0);
        check("t2_stall_cycles", 32'(sc2), 3);
        check("t2_hazard_events", 32'(ev2), 1);

        // 3: flush on the second cycle of the stall aborts it
        do_reset();
        load_use();
        step();
        clear_exe();
        flush = 1;
        #1 check("t3_hazard_flush", 32'(hz[1]), 0);
        step();
        flush = 0;
        #1 check("t3_hazard_after", 32'(hz[1]), 0);
        check("t3_stall_cycles", 32'(sc2), 1);
        check("t3_hazard_events", 32'(ev2), 1);

        // 4: non-forwarding mode, MEM producer and register 0
        do_reset();
        forward_en = 0; mem_wb_en = 1; mem_dest = 4'd5; src1 = 4'd5; src1_vld = 1;
        #1 check("t4_mem_match", 32'(hz[0]), 1);
        src1_vld = 0;
        #1 check("t4_src1_invalid", 32'(hz[0]), 0);
        mem_wb_en = 0; exe_wb_en = 1; exe_dest = 4'd0; src2 = 4'd0; src2_vld = 1;
        #1 check("t4_r0_match", 32'(hz[0]), 1);
        step();

        // 5: forwarding resolves a non-load producer
        idle();
        forward_en = 1; exe_wb_en = 1; exe_dest = 4'd7; src1 = 4'd7; src1_vld = 1;
        #1 check("t5_forwarded", 32'(hz[0]), 0);
        mem_wb_en = 1; mem_dest = 4'd7;
        #1 check("t5_forwarded_mem", 32'(hz[1]), 0);
        step();

        // 6: saturation with PW=4, then async reset mid-stall
        do_reset();
        forward_en = 0; mem_wb_en = 1; mem_dest = 4'd9; src2 = 4'd9; src2_vld = 1;
        repeat (20) @(posedge clk);
        #1;
        idle();
        #1 check("t6_sat_stall_cycles", 32'(sc4), 15);
        check("t6_sat_hazard_events", 32'(ev4), 15);
        check("t6_wide_stall_cycles", 32'(sc0), 20);
        load_use();
        step();
        clear_exe();
        #1 check("t6_in_stall", 32'(hz[2]), 1);
        rst = 0;
        #1 check("t6_rst_hazard", 32'(hz[2]), 0);
        check("t6_rst_bubble", 32'(bb[1]), 0);
        check("t6_rst_stall_cycles", 32'(sc4), 0);
        check("t6_rst_hazard_events", 32'(ev2), 0);
        step();
        rst = 1;
        load_use();
        #1 check("t6_post_rst_raw", 32'(hz[1]), 1);
        step();
        clear_exe();
        #1 check("t6_post_rst_events", 32'(ev2), 1);
        repeat (4) step();
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
        $finish;
    end

endmodule
